// File: rtl/uart_rx_responder.sv
// Memory-mapped 8N1 UART receiver with 16x oversampling. It exposes RXD/CON registers on the
// CPU data bus and raises a registered level interrupt while a received byte is pending.
module uart_rx_responder #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        rx_i,
  output logic        irq_o
);
  localparam int unsigned DIV      = CLK_HZ / (BAUD * 16);
  localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic [3:0]      scnt_q, scnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            rx_m_q, rx_s_q;
  logic [7:0]      rxd_q, rxd_d;
  logic            valid_q, valid_d, ovr_q, ovr_d, fe_q, fe_d;
  logic            ien_q, ien_d, irq_q, irq_d;
  logic            tick, byte_done, frame_bad;
  logic            sel_rxd, sel_con, rd_rxd, wr_con;
  logic            unused_bits;

  assign unused_bits = ^{wdata_i[31:4], wdata_i[0], addr_i[1:0]};

  assign tick = (tcnt_q == CW'(DIV - 1));

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    // Held at zero in IDLE, so the divider phase restarts as the FSM leaves it.
    tcnt_d    = (state_q == IDLE || tick) ? '0 : tcnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        scnt_d = '0;
        bidx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: if (tick) begin
        if (scnt_q == 4'd7) begin
          scnt_d  = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else scnt_d = scnt_q + 4'd1;
      end
      DATA: if (tick) begin
        scnt_d = scnt_q + 4'd1;
        if (scnt_q == 4'd15) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: if (tick) begin
        scnt_d = scnt_q + 4'd1;
        if (scnt_q == 4'd15) begin
          state_d   = IDLE;
          byte_done = rx_s_q;
          frame_bad = !rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_rxd = (addr_i[31:2] == BASE_ADDR[31:2]);
  assign sel_con = (addr_i[31:2] == CON_ADDR[31:2]);
  assign rd_rxd  = rd_i & sel_rxd;
  assign wr_con  = wr_i & sel_con;

  // Flag sets from the receiver take priority over CPU-side clears in the same cycle.
  always_comb begin
    rxd_d   = byte_done ? shreg_q : rxd_q;
    valid_d = byte_done | (valid_q & ~rd_rxd);
    ovr_d   = (byte_done & valid_q & ~rd_rxd) | (ovr_q & ~rd_rxd & ~(wr_con & wdata_i[2]));
    fe_d    = frame_bad | (fe_q & ~(wr_con & wdata_i[1]));
    ien_d   = wr_con ? wdata_i[3] : ien_q;
    irq_d   = ien_q & valid_q;
  end

  always_comb begin
    rdata_o = 32'd0;
    if (sel_rxd)      rdata_o = {24'd0, rxd_q};
    else if (sel_con) rdata_o = {28'd0, ien_q, ovr_q, fe_q, valid_q};
  end

  assign irq_o = irq_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      rxd_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      ien_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      rx_m_q  <= rx_i;
      rx_s_q  <= rx_m_q;
      rxd_q   <= rxd_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      ien_q   <= ien_d;
      irq_q   <= irq_d;
    end
  end
endmodule
